// File: rtl/hex_ascii_sender_pkg.sv
// Shared types and ASCII constants for the hex print path.
package hex_ascii_sender_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIGIT = 2'd1,
        ST_CR    = 2'd2,
        ST_LF    = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_NUL     = 8'h00;

endpackage

// File: rtl/hex_ascii_sender_nibble_to_ascii.sv
// Maps one 4-bit nibble to its uppercase ASCII hex digit.
module nibble_to_ascii
    import hex_ascii_sender_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_char
);

    logic [7:0] w_wide;

    assign w_wide = {4'h0, i_nibble};

    always_comb begin
        if (i_nibble < 4'd10) begin
            o_char = ASCII_ZERO + w_wide;
        end else begin
            o_char = ASCII_UPPER_A + (w_wide - 8'd10);
        end
    end

endmodule

// File: rtl/hex_ascii_sender.sv
// Prints a binary value as uppercase hex ASCII, MSB nibble first,
// one character per valid/ready transfer, with optional CR/LF.
module hex_ascii_sender
    import hex_ascii_sender_pkg::*;
#(
    parameter int NIBBLES        = 2,
    parameter bit APPEND_NEWLINE = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4*NIBBLES-1:0]   in_value,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             out_char,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t               r_state;
    logic [IW-1:0]        r_idx;
    logic [4*NIBBLES-1:0] r_value;

    logic [4*NIBBLES-1:0] w_shifted;
    logic [3:0]           w_nib;
    logic [7:0]           w_digit;
    logic                 w_xfer;

    // Nibble select as a shift keeps the index width independent of NIBBLES.
    assign w_shifted = r_value >> {r_idx, 2'b00};
    assign w_nib     = w_shifted[3:0];

    nibble_to_ascii u_n2a (
        .i_nibble (w_nib),
        .o_char   (w_digit)
    );

    assign out_valid = (r_state != ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign in_ready  = (r_state == ST_IDLE);
    assign w_xfer    = out_valid & out_ready;

    always_comb begin
        out_char = ASCII_NUL;
        unique case (r_state)
            ST_DIGIT: out_char = w_digit;
            ST_CR:    out_char = ASCII_CR;
            ST_LF:    out_char = ASCII_LF;
            default:  out_char = ASCII_NUL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_value <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_value <= in_value;
                        r_idx   <= LAST_IDX;
                        r_state <= ST_DIGIT;
                    end
                end
                ST_DIGIT: begin
                    if (w_xfer) begin
                        if (r_idx != '0) begin
                            r_idx <= r_idx - 1'b1;
                        end else if (APPEND_NEWLINE) begin
                            r_state <= ST_CR;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_CR: begin
                    if (w_xfer) begin
                        r_state <= ST_LF;
                    end
                end
                ST_LF: begin
                    if (w_xfer) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_ascii_sender.sv
// Directed bench for hex_ascii_sender (2-digit+CRLF and 4-digit bare).
module tb_hex_ascii_sender;

    logic        clk;
    logic        reset;
    logic [7:0]  in_value2;
    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  out_char2;
    logic        out_valid2;
    logic        busy2;
    logic [15:0] in_value4;
    logic        in_valid4;
    logic        in_ready4;
    logic [7:0]  out_char4;
    logic        out_valid4;
    logic        busy4;
    logic        out_ready;

    int asserts;
    int fails;
    logic [7:0] cap[$];
    int cyc;
    int hbad;

    hex_ascii_sender #(.NIBBLES(2), .APPEND_NEWLINE(1'b1)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_value  (in_value2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .out_char  (out_char2),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .busy      (busy2)
    );

    hex_ascii_sender #(.NIBBLES(4), .APPEND_NEWLINE(1'b0)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_value  (in_value4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .out_char  (out_char4),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .busy      (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; leaves time at the negedge after acceptance.
    task automatic accept(input bit sel, input logic [15:0] v);
        if (sel) begin
            in_value4 = v;
            in_valid4 = 1'b1;
        end else begin
            in_value2 = v[7:0];
            in_valid2 = 1'b1;
        end
        @(negedge clk);
        in_valid2 = 1'b0;
        in_valid4 = 1'b0;
    endtask

    // Drains characters, stalling 'stall' cycles before each transfer.
    task automatic collect(input bit sel, input int stall, input bit inject);
        logic [7:0] prev;
        logic [7:0] cur;
        int held;
        cap.delete();
        cyc = 0;
        hbad = 0;
        held = 0;
        prev = 8'h00;
        while (cyc < 200) begin
            if (!(sel ? out_valid4 : out_valid2)) break;
            cur = sel ? out_char4 : out_char2;
            if (held > 0 && cur !== prev) hbad++;
            if (inject) begin
                if (cyc == 1) begin
                    in_value2 = 8'h55;
                    in_valid2 = 1'b1;
                end else if (cyc == 2) begin
                    in_valid2 = 1'b0;
                end
            end
            if (held < stall) begin
                out_ready = 1'b0;
                held++;
                prev = cur;
            end else begin
                out_ready = 1'b1;
                cap.push_back(cur);
                held = 0;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid2 = 1'b0;
        if (cyc >= 200) begin
            asserts++;
            fails++;
            $display("FAIL collect_timeout: cycles=%0d required <200", cyc);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        asserts++;
        if (out_valid2 !== 1'b0 || out_char2 !== 8'h00 ||
            in_ready2 !== 1'b1 || busy2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_dut2: ov=%b oc=%h ir=%b busy=%b required 0 00 1 0",
                     out_valid2, out_char2, in_ready2, busy2);
        end
        asserts++;
        if (out_valid4 !== 1'b0 || out_char4 !== 8'h00 ||
            in_ready4 !== 1'b1 || busy4 !== 1'b0) begin
            fails++;
            $display("FAIL reset_dut4: ov=%b oc=%h ir=%b busy=%b required 0 00 1 0",
                     out_valid4, out_char4, in_ready4, busy4);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_seq(input string name, input logic [7:0] e0,
                             input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3);
        logic [7:0] exp_q[$];
        exp_q = '{e0, e1, e2, e3};
        asserts++;
        if (cap.size() != 4) begin
            fails++;
            $display("FAIL %s_count: got %0d chars required 4", name, cap.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                asserts++;
                if (cap[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL %s_char%0d: got %h required %h",
                             name, i, cap[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_basic;
        asserts++;
        if (in_ready2 !== 1'b1) begin
            fails++;
            $display("FAIL basic_ready_pre: got %b required 1", in_ready2);
        end
        accept(1'b0, 16'h003A);
        asserts++;
        if (out_valid2 !== 1'b1 || busy2 !== 1'b1 || in_ready2 !== 1'b0) begin
            fails++;
            $display("FAIL basic_latency: ov=%b busy=%b ir=%b required 1 1 0",
                     out_valid2, busy2, in_ready2);
        end
        collect(1'b0, 0, 1'b0);
        check_seq("basic", 8'h33, 8'h41, 8'h0D, 8'h0A);
        asserts++;
        if (cyc != 4) begin
            fails++;
            $display("FAIL basic_cycles: got %0d required 4", cyc);
        end
        asserts++;
        if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle_after: ir=%b ov=%b required 1 0",
                     in_ready2, out_valid2);
        end
    endtask

    task automatic test_backpressure;
        accept(1'b0, 16'h003A);
        collect(1'b0, 3, 1'b0);
        check_seq("stall", 8'h33, 8'h41, 8'h0D, 8'h0A);
        asserts++;
        if (hbad != 0) begin
            fails++;
            $display("FAIL stall_hold: got %0d changes required 0", hbad);
        end
        asserts++;
        if (cyc != 16) begin
            fails++;
            $display("FAIL stall_cycles: got %0d required 16", cyc);
        end
    endtask

    task automatic test_no_newline;
        asserts++;
        if (in_ready4 !== 1'b1) begin
            fails++;
            $display("FAIL nonl_ready_pre: got %b required 1", in_ready4);
        end
        accept(1'b1, 16'hF09C);
        collect(1'b1, 0, 1'b0);
        check_seq("nonl", 8'h46, 8'h30, 8'h39, 8'h43);
        asserts++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || out_char4 !== 8'h00) begin
            fails++;
            $display("FAIL nonl_idle_after: ir=%b ov=%b oc=%h required 1 0 00",
                     in_ready4, out_valid4, out_char4);
        end
    endtask

    task automatic test_boundaries;
        accept(1'b0, 16'h0000);
        collect(1'b0, 0, 1'b0);
        check_seq("v00", 8'h30, 8'h30, 8'h0D, 8'h0A);
        accept(1'b0, 16'h00FF);
        collect(1'b0, 1, 1'b0);
        check_seq("vFF", 8'h46, 8'h46, 8'h0D, 8'h0A);
        accept(1'b0, 16'h009A);
        collect(1'b0, 0, 1'b0);
        check_seq("v9A", 8'h39, 8'h41, 8'h0D, 8'h0A);
    endtask

    task automatic test_busy_ignore;
        accept(1'b0, 16'h003A);
        collect(1'b0, 0, 1'b1);
        check_seq("busy_ign", 8'h33, 8'h41, 8'h0D, 8'h0A);
        asserts++;
        if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
            fails++;
            $display("FAIL busy_ign_queued: ov=%b ir=%b required 0 1",
                     out_valid2, in_ready2);
        end
        accept(1'b0, 16'h0055);
        collect(1'b0, 0, 1'b0);
        check_seq("re55", 8'h35, 8'h35, 8'h0D, 8'h0A);
    endtask

    task automatic test_reset_mid;
        int seen;
        accept(1'b0, 16'h003A);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        asserts++;
        if (out_valid2 !== 1'b1 || out_char2 !== 8'h41) begin
            fails++;
            $display("FAIL rmid_second: ov=%b oc=%h required 1 41",
                     out_valid2, out_char2);
        end
        #2 reset = 1'b1;
        #1;
        asserts++;
        if (out_valid2 !== 1'b0) begin
            fails++;
            $display("FAIL rmid_async_drop: ov=%b required 0", out_valid2);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        asserts++;
        if (in_ready2 !== 1'b1 || busy2 !== 1'b0) begin
            fails++;
            $display("FAIL rmid_ready: ir=%b busy=%b required 1 0",
                     in_ready2, busy2);
        end
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid2 === 1'b1) seen++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        asserts++;
        if (seen != 0) begin
            fails++;
            $display("FAIL rmid_stale: got %0d valid cycles required 0", seen);
        end
    endtask

    initial begin
        asserts   = 0;
        fails     = 0;
        reset     = 1'b1;
        in_value2 = 8'h00;
        in_valid2 = 1'b0;
        in_value4 = 16'h0000;
        in_valid4 = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_no_newline();
        test_boundaries();
        test_busy_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule
